// File: rtl/jump_branch_pkg.sv
// Shared encodings for the flow-control sequencer and the main control unit.
package jump_branch_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10,
    PCS_REGA   = 2'b11
  } pc_source_t;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10
  } reg_dst_t;

  typedef enum logic [1:0] {
    M2R_ALUOUT = 2'b00,
    M2R_MDR    = 2'b01,
    M2R_PC     = 2'b10
  } mem_to_reg_t;

  typedef enum logic [1:0] {
    SRCB_REGB   = 2'b00,
    SRCB_FOUR   = 2'b01,
    SRCB_IMM_SH = 2'b11
  } alu_src_b_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001
  } alu_op_t;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_J_EXEC  = 4'd1,
    S_LINK    = 4'd2,
    S_JR_EXEC = 4'd3,
    S_BR_CALC = 4'd4,
    S_BR_CMP  = 4'd5,
    S_DONE    = 4'd6
  } state_t;

  typedef struct packed {
    logic        pc_write;
    pc_source_t  pc_source;
    logic        reg_write;
    reg_dst_t    reg_dst_sel;
    mem_to_reg_t mem_to_reg_sel;
    logic        alu_src_a;
    alu_src_b_t  alu_src_b;
    alu_op_t     alu_op;
    logic        alu_out_write;
    logic        busy;
    logic        done;
    logic        illegal;
  } ctrl_t;

endpackage

// File: rtl/jump_branch_sequencer.sv
// Multicycle sub-controller sequencing PC update and link write for J/JAL/JR/JALR/BEQ/BNE.
module jump_branch_sequencer
  import jump_branch_pkg::*;
#(
  parameter bit         SUPPORT_JALR = 1'b1,
  parameter logic [4:0] LINK_REG     = 5'd31
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       reg_write,
  output logic [1:0] reg_dst_sel,
  output logic [1:0] mem_to_reg_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       alu_out_write,
  output logic       busy,
  output logic       done,
  output logic       illegal,
  output logic [3:0] current_state
);

  // The link register index is consumed by the datapath mux; r0 would discard the link.
  if (LINK_REG == 5'd0) begin : g_link_reg_check
    $error("LINK_REG must not be r0");
  end

  state_t     state, nxt;
  logic [5:0] op_q, fn_q, op_d, fn_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       br_take;

  function automatic state_t dispatch(input logic [5:0] op, input logic [5:0] fn);
    state_t s;
    s = S_DONE;
    case (op)
      OP_J:           s = S_J_EXEC;
      OP_JAL:         s = S_LINK;
      OP_BEQ, OP_BNE: s = S_BR_CALC;
      OP_RTYPE: begin
        if (fn == FN_JR)                        s = S_JR_EXEC;
        else if (fn == FN_JALR && SUPPORT_JALR) s = S_LINK;
      end
      default:        s = S_DONE;
    endcase
    return s;
  endfunction

  // Outputs are decoded for the state being entered so they register in step with it.
  function automatic ctrl_t decode(input state_t s, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    c.busy = (s != S_IDLE);
    case (s)
      S_J_EXEC: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_JUMP;
      end
      S_LINK: begin
        c.reg_write      = 1'b1;
        c.mem_to_reg_sel = M2R_PC;
        c.reg_dst_sel    = (op == OP_JAL) ? DST_LINK : DST_RD;
      end
      S_JR_EXEC: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCS_REGA;
      end
      S_BR_CALC: begin
        c.alu_src_a     = 1'b0;
        c.alu_src_b     = SRCB_IMM_SH;
        c.alu_op        = ALU_ADD;
        c.alu_out_write = 1'b1;
      end
      S_BR_CMP: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REGB;
        c.alu_op    = ALU_SUB;
        c.pc_source = PCS_ALUOUT;
      end
      S_DONE: begin
        c.done    = 1'b1;
        c.illegal = (dispatch(op, fn) == S_DONE);
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt  = S_IDLE;
    op_d = op_q;
    fn_d = fn_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          op_d = opcode;
          fn_d = funct;
          nxt  = dispatch(opcode, funct);
        end
      end
      S_LINK:                         nxt = (op_q == OP_JAL) ? S_J_EXEC : S_JR_EXEC;
      S_BR_CALC:                      nxt = S_BR_CMP;
      S_J_EXEC, S_JR_EXEC, S_BR_CMP:  nxt = S_DONE;
      default:                        nxt = S_IDLE;
    endcase
    ctrl_d = decode(nxt, op_d, fn_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= '0;
      fn_q   <= '0;
      ctrl_q <= '0;
    end else begin
      state  <= nxt;
      op_q   <= op_d;
      fn_q   <= fn_d;
      ctrl_q <= ctrl_d;
    end
  end

  // The branch decision follows the ALU zero flag within the compare cycle.
  assign br_take = (state == S_BR_CMP) && (zero ^ (op_q == OP_BNE));

  assign pc_write       = ctrl_q.pc_write | br_take;
  assign pc_source      = ctrl_q.pc_source;
  assign reg_write      = ctrl_q.reg_write;
  assign reg_dst_sel    = ctrl_q.reg_dst_sel;
  assign mem_to_reg_sel = ctrl_q.mem_to_reg_sel;
  assign alu_src_a      = ctrl_q.alu_src_a;
  assign alu_src_b      = ctrl_q.alu_src_b;
  assign alu_op         = ctrl_q.alu_op;
  assign alu_out_write  = ctrl_q.alu_out_write;
  assign busy           = ctrl_q.busy;
  assign done           = ctrl_q.done;
  assign illegal        = ctrl_q.illegal;
  assign current_state  = state;

endmodule
